// File: rtl/stick_stepper_pkg.sv
// stick_stepper_pkg: shared direction/state encodings and stick calibration defaults.
package stick_stepper_pkg;

    typedef enum logic [1:0] {
        DIR_NEUTRAL = 2'b00,
        DIR_LEFT    = 2'b01,
        DIR_RIGHT   = 2'b10
    } dir_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_e;

    localparam int CENTER_DEF   = 512;
    localparam int DEADZONE_DEF = 128;
    localparam int HYST_DEF     = 32;

endpackage

// File: rtl/stick_avg4.sv
// stick_avg4: 4-sample moving average of the raw X axis; reports CENTER until 4 samples are held.
module stick_avg4
    import stick_stepper_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int CENTER = CENTER_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] pos_data,
    input  logic              pos_valid,
    output logic [DATA_W-1:0] avg
);

    logic [3:0][DATA_W-1:0] smp_q, smp_d;
    logic [2:0]             fill_q, fill_d;
    logic [DATA_W+1:0]      sum_d;
    logic [DATA_W-1:0]      avg_q, avg_d;

    // The average is taken over the buffer including the incoming sample so avg lands one cycle after the strobe.
    always_comb begin
        smp_d  = pos_valid ? {smp_q[2:0], pos_data} : smp_q;
        fill_d = (pos_valid && fill_q != 3'd4) ? fill_q + 3'd1 : fill_q;
        sum_d  = {2'b0, smp_d[0]} + {2'b0, smp_d[1]} + {2'b0, smp_d[2]} + {2'b0, smp_d[3]};
        avg_d  = !pos_valid ? avg_q : fill_d == 3'd4 ? DATA_W'(sum_d >> 2) : DATA_W'(CENTER);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            smp_q  <= '0;
            fill_q <= '0;
            avg_q  <= DATA_W'(CENTER);
        end else begin
            smp_q  <= smp_d;
            fill_q <= fill_d;
            avg_q  <= avg_d;
        end
    end

    assign avg = avg_q;

endmodule

// File: rtl/stick_stepper.sv
// stick_stepper: joystick X samples -> averaged deadzone direction -> auto-repeat lane stepping.
// Define STICK_HYST_EN to give the classifier exit hysteresis.
module stick_stepper
    import stick_stepper_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int POS_W        = 4,
    parameter int POS_MAX      = 15,
    parameter int POS_INIT     = 7,
    parameter int CENTER       = CENTER_DEF,
    parameter int DEADZONE     = DEADZONE_DEF,
    parameter int FIRST_TICKS  = 8,
    parameter int REPEAT_TICKS = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] pos_data,
    input  logic              pos_valid,
    input  logic              step_tick,
    input  logic              freeze,
    output logic [POS_W-1:0]  plrpos,
    output logic              step_pulse,
    output logic [1:0]        dir
);

    localparam int CNT_W = $clog2(FIRST_TICKS + 1);
    localparam logic [DATA_W-1:0] LO = DATA_W'(CENTER - DEADZONE);
    localparam logic [DATA_W-1:0] HI = DATA_W'(CENTER + DEADZONE);

    logic [DATA_W-1:0] avg;
    dir_e              dir_q, dir_d, run_q, run_d, step_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              pulse_q, pulse_d;

    stick_avg4 #(.DATA_W(DATA_W), .CENTER(CENTER)) u_avg (
        .clk       (clk),
        .clr       (clr),
        .pos_data  (pos_data),
        .pos_valid (pos_valid),
        .avg       (avg)
    );

`ifdef STICK_HYST_EN
    localparam logic [DATA_W-1:0] LO_EXIT = DATA_W'(CENTER - DEADZONE + HYST_DEF);
    localparam logic [DATA_W-1:0] HI_EXIT = DATA_W'(CENTER + DEADZONE - HYST_DEF);
    logic [1:0] prev_q;

    always_comb
        dir_d = avg < LO ? DIR_LEFT : avg > HI ? DIR_RIGHT
              : (prev_q == DIR_LEFT && avg < LO_EXIT) ? DIR_LEFT
              : (prev_q == DIR_RIGHT && avg > HI_EXIT) ? DIR_RIGHT : DIR_NEUTRAL;

    always_ff @(posedge clk)
        prev_q <= !clr ? DIR_NEUTRAL : dir_d;
`else
    always_comb
        dir_d = avg < LO ? DIR_LEFT : avg > HI ? DIR_RIGHT : DIR_NEUTRAL;
`endif

    // run_q remembers the direction being repeated so a reversal restarts the first-step delay.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        step_d  = DIR_NEUTRAL;
        if (freeze || dir_q == DIR_NEUTRAL) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE || dir_q != run_q) begin
            step_d  = dir_q;
            run_d   = dir_q;
            cnt_d   = CNT_W'(FIRST_TICKS);
            state_d = DELAY;
        end else if (step_tick) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                step_d  = dir_q;
                cnt_d   = CNT_W'(REPEAT_TICKS);
                state_d = REPEAT;
            end
        end
        pos_d   = (step_d == DIR_LEFT && pos_q != '0) ? pos_q - 1'b1
                : (step_d == DIR_RIGHT && pos_q != POS_W'(POS_MAX)) ? pos_q + 1'b1 : pos_q;
        pulse_d = pos_d != pos_q;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            dir_q   <= DIR_NEUTRAL;
            run_q   <= DIR_NEUTRAL;
            state_q <= IDLE;
            cnt_q   <= '0;
            pos_q   <= POS_W'(POS_INIT);
            pulse_q <= 1'b0;
        end else begin
            dir_q   <= dir_d;
            run_q   <= run_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            pulse_q <= pulse_d;
        end
    end

    assign plrpos     = pos_q;
    assign step_pulse = pulse_q;
    assign dir        = dir_q;

endmodule

// File: doc/stick_stepper.md
Name: stick_stepper

Overview:
- Converts the joystick's raw 10-bit X-axis sample stream into the 4-bit player lane position consumed by the game and vga stages.
- Sits between the joystick SPI interface (posData plus a sample strobe) and the game/vga logic (plrpos).
- Stages: 4-sample moving average, deadzone classification, auto-repeat stepping FSM.
- Runs on the 100 MHz system clock; step timing comes from a one-cycle tick enable driven by clockdiv.

Parameters:
- DATA_W, 10, joystick sample width.
- POS_W, 4, player position width.
- POS_MAX, 15, highest legal position.
- POS_INIT, 7, position after reset.
- CENTER, 512, stick rest value.
- DEADZONE, 128, half-width of the neutral band.
- FIRST_TICKS, 8, ticks before auto-repeat begins.
- REPEAT_TICKS, 3, ticks between repeated steps.

Ports:
- clk, in, 1, system clock; all logic on the rising edge.
- clr, in, 1, reset; synchronous, active-low.
- pos_data, in, DATA_W, raw X sample.
- pos_valid, in, 1, one-cycle strobe qualifying pos_data.
- step_tick, in, 1, one-cycle step-timing enable.
- freeze, in, 1, suppresses all stepping (game over / pause).
- plrpos, out, POS_W, current player position.
- step_pulse, out, 1, high for one cycle when plrpos changes.
- dir, out, 2, registered direction: 00 neutral, 01 left, 10 right; 11 never driven.

Behaviour:
- Reset: clr==0 sampled at a clk edge resets the block. Reset values:
  - plrpos=POS_INIT, step_pulse=0, dir=00, state=IDLE.
  - Sample buffer cleared, fill count=0, avg=CENTER, tick counter=0.
  - Reset mid-repeat aborts with no further step.
- Averager:
  - On pos_valid, the sample shifts into a 4-entry buffer and fill count increments, saturating at 4.
  - sum = DATA_W+2 bits. Cycle N+1 after pos_valid: avg = sum>>2 if fill==4, else CENTER.
- Classifier, registered at N+2:
  - avg < CENTER-DEADZONE -> left.
  - avg > CENTER+DEADZONE -> right.
  - Otherwise neutral; band edges are neutral.
- FSM states IDLE, DELAY, REPEAT; steps are evaluated against the registered dir.
  - IDLE: dir non-neutral and freeze==0 -> step now, load counter=FIRST_TICKS, go to DELAY.
  - DELAY: counter decrements on step_tick. On the tick that reaches 0: step, load REPEAT_TICKS, go to REPEAT.
  - REPEAT: same countdown; step at each expiry, then reload REPEAT_TICKS.
  - dir becomes neutral -> IDLE, no step.
  - dir reverses -> immediate step in the new direction, reload FIRST_TICKS, go to DELAY.
  - freeze==1 -> IDLE, counter cleared, no step; stepping restarts from IDLE when freeze drops and dir is non-neutral.
- Step:
  - Left decrements, right increments, saturating at 0 / POS_MAX.
  - A saturated step leaves plrpos unchanged, keeps step_pulse=0, and the FSM still advances.
  - plrpos and step_pulse register one cycle after the step decision.
  - End-to-end latency from IDLE: pos_valid at N -> plrpos updated at N+3.
- Simultaneous pos_valid and step_tick: both act that cycle; the countdown uses the dir already registered.
- Only one step can occur per cycle.

Optional Feature:
- STICK_HYST_EN defined: classifier uses hysteresis.
  - Once left, stays left until avg >= CENTER-DEADZONE+32.
  - Once right, stays right until avg <= CENTER+DEADZONE-32.
  - Entry thresholds unchanged.
  - Adds a 2-bit previous-direction register, reset to neutral.
- Not defined: pure threshold comparison as above; no extra state.

Decomposition:
- Shared package holds:
  - Direction encodings DIR_NEUTRAL/DIR_LEFT/DIR_RIGHT.
  - FSM state encodings.
  - Default CENTER/DEADZONE constants, reused by vga for the debug overlay.
- One natural sub-module: stick_avg4 (buffer, fill count, sum, avg register).
- Classifier and FSM stay in stick_stepper.

Test Plan:
- Reset then 4 samples of 900 with pos_valid -> dir=10 at the cycle after avg updates; plrpos 7->8 with step_pulse exactly 3 cycles after the 4th strobe.
- Hold 900 with continuous step_tick -> plrpos steps at tick 0, 8, 11, 14, ...; saturates at 15; step_pulse stays 0 after saturation.
- Samples 384 (band edge) then 383 -> dir 00 then 01; 383 gives a step left from IDLE.
- Holding left in REPEAT, feed 900 x4 -> passes through neutral/right; a step right occurs and FIRST_TICKS restarts.
- freeze=1 while in REPEAT -> no steps, state IDLE; freeze=0 with dir still left -> immediate step.
- clr=0 for one cycle mid-DELAY -> next cycle plrpos=7, dir=00, fill=0; 3 samples of 100 -> no step, since avg=CENTER until fill==4.
